// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, UART timing helpers and default widths (no macros)
package uart_pkg;

    typedef enum logic [1:0] {IDLE, STROBE, WAIT} state_t;

    localparam int default_width      = 8;
    localparam int default_addr_width = 8;

    function automatic int ticks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // one start bit, width data bits, one stop bit
    function automatic int frame_ticks(input int width, input int tpb);
        return (width + 2) * tpb;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored
module sync_fifo #(
    parameter int width = 8,
    parameter int depth = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [width-1:0]         wdata,
    output logic [width-1:0]         rdata,
    output logic [$clog2(depth):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int aw = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (aw+1)'(depth);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // storage is not reset; only the pointers and count define validity
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // pointers wrap naturally modulo depth; count separates full from empty
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (aw+1)'(do_push) - (aw+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: paces buffered bytes into buff_uart transmit strobes; optional stats via UART_TX_FEEDER_STATS_EN
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int width       = default_width,
    parameter int addr_width  = default_addr_width,
    parameter int tx_address  = 4,
    parameter int clock_freq  = 50_000_000,
    parameter int baud_rate   = 115200,
    parameter int depth       = 4,
    parameter int guard_ticks = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [width-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [addr_width-1:0]    bus_address,
    output logic                     bus_read_enable,
    output logic                     bus_write_enable,
    output logic [width-1:0]         bus_data,
    output logic                     busy,
`ifdef UART_TX_FEEDER_STATS_EN
    output logic [15:0]              tx_count,
    output logic [15:0]              drop_count,
`endif
    output logic [$clog2(depth):0]   fifo_count
);

    localparam int tpb = ticks_per_bit(clock_freq, baud_rate);
    localparam int gap = frame_ticks(width, tpb) + guard_ticks;
    localparam int cw  = $clog2(gap + 1);

    state_t           state;
    state_t           next_state;
    logic [cw-1:0]    gap_cnt;
    logic [width-1:0] head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             strobe_next;

    assign in_ready         = !full && !reset;
    assign push             = in_valid && in_ready;
    assign pop              = state == STROBE;
    assign busy             = !empty || state != IDLE;
    assign bus_write_enable = 1'b0;
    assign strobe_next      = next_state == STROBE;

    sync_fifo #(.width(width), .depth(depth)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    // a pending byte at the end of the gap goes straight to STROBE so strobes are gap+1 cycles apart
    always_comb begin
        next_state = state;
        next_state = (state == IDLE)   ? (empty ? IDLE : STROBE) :
                     (state == STROBE) ? WAIT :
                     (gap_cnt != '0)   ? WAIT :
                     (empty ? IDLE : STROBE);
    end

    // state, gap counter and registered bus strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            bus_read_enable <= 1'b0;
            bus_address     <= '0;
            bus_data        <= '0;
        end else begin
            state           <= next_state;
            gap_cnt         <= (state == STROBE) ? cw'(gap - 1) : (gap_cnt != '0) ? gap_cnt - 1'b1 : gap_cnt;
            bus_read_enable <= strobe_next;
            bus_address     <= strobe_next ? addr_width'(tx_address) : '0;
            bus_data        <= strobe_next ? head : '0;
        end
    end

`ifdef UART_TX_FEEDER_STATS_EN
    // saturating counts of issued strobes and refused input cycles
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_count   <= '0;
            drop_count <= '0;
        end else begin
            if (pop && tx_count != 16'hFFFF) tx_count <= tx_count + 1'b1;
            if (in_valid && !in_ready && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
        end
    end
`endif

endmodule
